// File: rtl/letc_core_pkg.sv
// Shared core types: ALU and multiply/divide operation encodings plus small op-decode helpers.
package letc_core_pkg;

    typedef enum logic [3:0] {
        AluAdd  = 4'd0,
        AluSub  = 4'd1,
        AluSll  = 4'd2,
        AluSlt  = 4'd3,
        AluSltu = 4'd4,
        AluXor  = 4'd5,
        AluSrl  = 4'd6,
        AluSra  = 4'd7,
        AluOr   = 4'd8,
        AluAnd  = 4'd9
    } alu_op_e;

    // Encoding matches the RV32M funct3 field.
    typedef enum logic [2:0] {
        MdMul    = 3'b000,
        MdMulh   = 3'b001,
        MdMulhsu = 3'b010,
        MdMulhu  = 3'b011,
        MdDiv    = 3'b100,
        MdDivu   = 3'b101,
        MdRem    = 3'b110,
        MdRemu   = 3'b111
    } muldiv_op_e;

    function automatic logic op_is_mul(input muldiv_op_e op);
        return !op[2];
    endfunction

    function automatic logic op_signed_a(input muldiv_op_e op);
        return op inside {MdMulh, MdMulhsu, MdDiv, MdRem};
    endfunction

    function automatic logic op_signed_b(input muldiv_op_e op);
        return op inside {MdMulh, MdDiv, MdRem};
    endfunction

endpackage

// File: rtl/letc_core_muldiv_if.sv
// Execute-stage to multiply/divide unit handshake bundle.
interface letc_core_muldiv_if;
    import letc_core_pkg::*;

    logic        start;
    logic        flush;
    muldiv_op_e  op;
    logic [31:0] operand_a;
    logic [31:0] operand_b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    modport master (
        output start, flush, op, operand_a, operand_b,
        input  busy, done, result
    );

    modport slave (
        input  start, flush, op, operand_a, operand_b,
        output busy, done, result
    );

endinterface

// File: rtl/letc_core_div_step.sv
// One restoring-division step: trial subtract of the divisor from the shifted partial remainder.
module letc_core_div_step (
    input  logic [32:0] partial,
    input  logic [31:0] divisor,
    output logic [31:0] remainder,
    output logic        q_bit
);

    logic [33:0] diff;
    logic        unused_diff;

    always_comb begin
        diff      = {1'b0, partial} - {2'b00, divisor};
        q_bit     = ~diff[33];
        // A successful subtract always leaves less than the divisor, so bit 32 is zero.
        remainder = q_bit ? diff[31:0] : partial[31:0];
    end

    assign unused_diff = diff[32];

endmodule

// File: rtl/letc_core_muldiv.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, fast special cases.
module letc_core_muldiv
    import letc_core_pkg::*;
#(
    parameter int unsigned MUL_BITS_PER_CYCLE = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    letc_core_muldiv_if.slave   bus
);

    localparam int unsigned MulIters = 32 / MUL_BITS_PER_CYCLE;
    localparam logic [5:0]  MulLast  = 6'(MulIters - 1);
    localparam logic [5:0]  DivLast  = 6'd31;
    localparam logic [5:0]  CntMax   = 6'd32;

    typedef enum logic [2:0] {
        StIdle,
        StMulIter,
        StDivIter,
        StFixup,
        StDone
    } state_e;

    state_e      state_q;
    muldiv_op_e  op_q;
    logic [63:0] acc_q;
    logic [63:0] mcand_q;
    logic [31:0] mplier_q;
    logic [31:0] a_raw_q;
    logic        neg_a_q, neg_b_q;
    logic        div0_q, ovf_q;
    logic [5:0]  cnt_q;
    logic        busy_q, done_q;
    logic [31:0] result_q;

    logic        accept;
    logic        neg_a, neg_b;
    logic [31:0] mag_a, mag_b;
    logic        is_ovf;

    always_comb begin
        accept = (state_q == StIdle || state_q == StDone) && bus.start && !bus.flush;
        neg_a  = op_signed_a(bus.op) && bus.operand_a[31];
        neg_b  = op_signed_b(bus.op) && bus.operand_b[31];
        mag_a  = neg_a ? -bus.operand_a : bus.operand_a;
        mag_b  = neg_b ? -bus.operand_b : bus.operand_b;
        is_ovf = op_signed_b(bus.op) && bus.operand_a == 32'h8000_0000 && bus.operand_b == '1;
    end

    logic [63:0] mul_partial;

    always_comb begin
        mul_partial = '0;
        for (int unsigned j = 0; j < MUL_BITS_PER_CYCLE; j++) begin
            if (mplier_q[j]) mul_partial = mul_partial + (mcand_q << j);
        end
    end

    // acc_q doubles as the {remainder, dividend/quotient} shift register while dividing.
    logic [32:0] div_partial;
    logic [31:0] div_rem;
    logic        div_q;

    assign div_partial = {acc_q[63:32], acc_q[31]};

    letc_core_div_step u_div_step (
        .partial   (div_partial),
        .divisor   (mplier_q),
        .remainder (div_rem),
        .q_bit     (div_q)
    );

    logic [63:0] prod;
    logic [31:0] quot, rmd, fix_result;

    always_comb begin
        prod = (neg_a_q ^ neg_b_q) ? -acc_q : acc_q;
        quot = (neg_a_q ^ neg_b_q) ? -acc_q[31:0] : acc_q[31:0];
        rmd  = neg_a_q ? -acc_q[63:32] : acc_q[63:32];
        if (div0_q) begin
            quot = '1;
            rmd  = a_raw_q;
        end else if (ovf_q) begin
            quot = 32'h8000_0000;
            rmd  = '0;
        end
        fix_result = '0;
        unique case (op_q)
            MdMul:                     fix_result = prod[31:0];
            MdMulh, MdMulhsu, MdMulhu: fix_result = prod[63:32];
            MdDiv, MdDivu:             fix_result = quot;
            MdRem, MdRemu:             fix_result = rmd;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            op_q     <= MdMul;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            a_raw_q  <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            div0_q   <= 1'b0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else if (bus.flush) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle, StDone: begin
                    if (accept) begin
                        op_q     <= bus.op;
                        a_raw_q  <= bus.operand_a;
                        neg_a_q  <= neg_a;
                        neg_b_q  <= neg_b;
                        mplier_q <= mag_b;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        div0_q   <= 1'b0;
                        ovf_q    <= 1'b0;
                        if (op_is_mul(bus.op)) begin
                            acc_q   <= '0;
                            mcand_q <= {32'b0, mag_a};
                            state_q <= StMulIter;
                        end else begin
                            acc_q   <= {32'b0, mag_a};
                            mcand_q <= '0;
                            if (bus.operand_b == '0) begin
                                div0_q  <= 1'b1;
                                state_q <= StFixup;
                            end else if (is_ovf) begin
                                ovf_q   <= 1'b1;
                                state_q <= StFixup;
                            end else begin
                                state_q <= StDivIter;
                            end
                        end
                    end else begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                end
                StMulIter: begin
                    acc_q    <= acc_q + mul_partial;
                    mcand_q  <= mcand_q << MUL_BITS_PER_CYCLE;
                    mplier_q <= mplier_q >> MUL_BITS_PER_CYCLE;
                    cnt_q    <= (cnt_q == CntMax) ? cnt_q : cnt_q + 6'd1;
                    if (cnt_q == MulLast) state_q <= StFixup;
                end
                StDivIter: begin
                    acc_q <= {div_rem, acc_q[30:0], div_q};
                    cnt_q <= (cnt_q == CntMax) ? cnt_q : cnt_q + 6'd1;
                    if (cnt_q == DivLast) state_q <= StFixup;
                end
                StFixup: begin
                    result_q <= fix_result;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                    state_q  <= StDone;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;

    a_no_x: assert property (@(posedge clk) disable iff (!rst_n)
        !$isunknown({busy_q, done_q, state_q}));
    a_done_single: assert property (@(posedge clk) disable iff (!rst_n)
        done_q && !accept |=> !done_q);
    a_done_not_busy: assert property (@(posedge clk) disable iff (!rst_n)
        done_q |-> !busy_q);
    a_no_start_busy: assert property (@(posedge clk) disable iff (!rst_n)
        !(busy_q && bus.start));

endmodule

// File: tb/tb_letc_core_muldiv.sv
// Directed scoreboard bench driving three unit instances (1, 2 and 4 multiplier bits per cycle).
module tb_letc_core_muldiv;
    import letc_core_pkg::*;

    typedef struct {
        logic [31:0] res;
        int          due;
        string       tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, flush;
    muldiv_op_e  op;
    logic [31:0] a, b;

    logic [2:0]  dn, bz;
    logic [31:0] rs [3];

    int   cyc = 0;
    int   n_vec = 0;
    int   n_fail = 0;
    exp_t sb [3][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    letc_core_muldiv_if bus [3] ();

    for (genvar g = 0; g < 3; g++) begin : g_dut
        letc_core_muldiv #(
            .MUL_BITS_PER_CYCLE (1 << g)
        ) u_dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus[g])
        );
        assign bus[g].start     = start;
        assign bus[g].flush     = flush;
        assign bus[g].op        = op;
        assign bus[g].operand_a = a;
        assign bus[g].operand_b = b;
        assign dn[g]            = bus[g].done;
        assign bz[g]            = bus[g].busy;
        assign rs[g]            = bus[g].result;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic int lat(input muldiv_op_e o, input logic [31:0] ia, input logic [31:0] ib,
                               input int bpc);
        if (o inside {MdMul, MdMulh, MdMulhsu, MdMulhu}) return 2 + 32 / bpc;
        if (ib == 0) return 2;
        if (o inside {MdDiv, MdRem} && ia == 32'h8000_0000 && ib == 32'hFFFF_FFFF) return 2;
        return 34;
    endfunction

    // Scoreboard: every done pops one expectation and checks value and arrival cycle.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            for (int i = 0; i < 3; i++) begin
                if (dn[i]) begin
                    if (sb[i].size() == 0) begin
                        check($sformatf("dut%0d spurious done", i), {31'b0, dn[i]}, 32'd0);
                    end else begin
                        exp_t e;
                        e = sb[i].pop_front();
                        check($sformatf("dut%0d %s result", i, e.tag), rs[i], e.res);
                        check($sformatf("dut%0d %s done cycle", i, e.tag), cyc, e.due);
                        check($sformatf("dut%0d %s busy at done", i, e.tag), {31'b0, bz[i]}, 32'd0);
                    end
                end else if (sb[i].size() != 0 && cyc > sb[i][0].due) begin
                    exp_t e;
                    e = sb[i].pop_front();
                    check($sformatf("dut%0d %s done timeout", i, e.tag), {31'b0, dn[i]}, 32'd1);
                end
            end
        end
    end

    // Called just after a rising edge; start is sampled on the following edge.
    task automatic issue(input muldiv_op_e o, input logic [31:0] ia, input logic [31:0] ib,
                         input logic [31:0] ie, input bit push, input string tag);
        op    = o;
        a     = ia;
        b     = ib;
        start = 1'b1;
        if (push) begin
            for (int i = 0; i < 3; i++) begin
                exp_t e;
                e.res = ie;
                e.due = cyc + lat(o, ia, ib, 1 << i);
                e.tag = tag;
                sb[i].push_back(e);
            end
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_all();
        int n = 0;
        while ((sb[0].size() + sb[1].size() + sb[2].size()) != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic run(input muldiv_op_e o, input logic [31:0] ia, input logic [31:0] ib,
                       input logic [31:0] ie, input string tag);
        issue(o, ia, ib, ie, 1'b1, tag);
        wait_all();
    endtask

    initial begin
        int t;
        int n;
        rst_n = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        op    = MdMul;
        a     = '0;
        b     = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("dut%0d reset busy", i), {31'b0, bz[i]}, 32'd0);
            check($sformatf("dut%0d reset done", i), {31'b0, dn[i]}, 32'd0);
            check($sformatf("dut%0d reset result", i), rs[i], 32'd0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        // MUL with busy window observed on the radix-2 instance.
        t = cyc;
        issue(MdMul, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b1, "mul 7*-3");
        check("busy at t+1", {31'b0, bz[0]}, 32'd1);
        repeat (32) begin @(posedge clk); #1; end
        check("busy at t+33", {31'b0, bz[0]}, 32'd1);
        check("cycle bookkeeping t+33", cyc, t + 33);
        @(posedge clk); #1;
        check("busy at t+34", {31'b0, bz[0]}, 32'd0);
        check("done at t+34", {31'b0, dn[0]}, 32'd1);
        wait_all();

        run(MdMulh,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh min*min");
        run(MdMulhu,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu max*max");
        run(MdMulhsu, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, "mulhsu -1*2");
        run(MdMulh,   32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, "mulh -3*5");
        run(MdDiv,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, "div -7/2");
        run(MdRem,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, "rem -7/2");
        run(MdRemu,   32'd100,       32'd7,         32'd2,         "remu 100/7");
        run(MdDivu,   32'd5,         32'd0,         32'hFFFF_FFFF, "divu 5/0");
        run(MdRemu,   32'd5,         32'd0,         32'd5,         "remu 5/0");
        run(MdDiv,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div ovf");
        run(MdRem,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         "rem ovf");
        run(MdDivu,   32'd100,       32'd7,         32'd14,        "divu 100/7");

        // Flush at t+10 of a divide: no done, result keeps 14, new MUL completes at t+45.
        t = cyc;
        issue(MdDiv, 32'd1000, 32'd3, 32'd0, 1'b0, "div flushed");
        repeat (9) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("dut%0d busy after flush", i), {31'b0, bz[i]}, 32'd0);
            check($sformatf("dut%0d result after flush", i), rs[i], 32'd14);
        end
        check("flush restart cycle", cyc, t + 11);
        run(MdMul, 32'd3, 32'd4, 32'd12, "mul 3*4 after flush");

        // Flush together with start: not accepted.
        op    = MdMul;
        a     = 32'd5;
        b     = 32'd5;
        start = 1'b1;
        flush = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        flush = 1'b0;
        for (int i = 0; i < 3; i++)
            check($sformatf("dut%0d busy after flush+start", i), {31'b0, bz[i]}, 32'd0);
        repeat (40) begin @(posedge clk); #1; end
        check("result after flush+start", rs[0], 32'd12);

        // Back-to-back: new start in the DONE cycle.
        issue(MdDivu, 32'd100, 32'd7, 32'd14, 1'b1, "divu b2b first");
        n = 0;
        while (!dn[0] && n < 60) begin
            @(posedge clk); #1;
            n++;
        end
        check("b2b done seen", {31'b0, dn[0]}, 32'd1);
        issue(MdMul, 32'd2, 32'd3, 32'd6, 1'b1, "mul 2*3 b2b");
        wait_all();

        // Reset mid-divide discards the work.
        issue(MdDiv, 32'd1000, 32'd3, 32'd0, 1'b0, "div reset");
        repeat (5) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("dut%0d busy after reset", i), {31'b0, bz[i]}, 32'd0);
            check($sformatf("dut%0d done after reset", i), {31'b0, dn[i]}, 32'd0);
            check($sformatf("dut%0d result after reset", i), rs[i], 32'd0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        run(MdMulhu, 32'h1234_5678, 32'h0001_0000, 32'h0000_1234, "mulhu after reset");

        for (int i = 0; i < 3; i++)
            check($sformatf("dut%0d scoreboard drained", i), sb[i].size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
